// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the ARM data-memory responder.
package arm_mem_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte address bits dropped to form a word index.
  localparam int unsigned WORD_OFFSET = 2;

  // Width of a word index for a RAM of the given depth.
  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    if (depth > 1) begin
      w = int'($clog2(depth));
    end
    return w;
  endfunction

endpackage

// File: rtl/arm_sp_ram.sv
// Synchronous single-port RAM with write enable and registered read port.
// The read register is resettable and can be forced to zero on demand;
// the storage array itself is never reset.
module arm_sp_ram #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned IDX_W    = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic                re_i,
  input  logic                clr_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  output logic [DATA_LEN-1:0] rdata_o
);

  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [DATA_LEN-1:0] rdata_q;

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Registered read data; holds its value unless a read or clear occurs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/arm_data_mem_responder.sv
// Data-memory responder for the ARM core MEM stage: request/ready handshake
// with WAIT_CYCLES wait states in front of a word-addressed single-port RAM.
// Optional MEM_RANGE_ERR_EN: adds the err port and flags out-of-range
// addresses instead of wrapping them modulo MEM_DEPTH.
module arm_data_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [ADDRESS_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0]    wdata,
  output logic [DATA_LEN-1:0]    rdata,
  output logic                   ready
`ifdef MEM_RANGE_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned IDX_W = idx_width(MEM_DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                oor_q, oor_d;
  logic                ready_q, ready_d;

  logic                req_c;
  logic [IDX_W-1:0]    in_idx_c;
  logic                in_oor_c;
  logic                fire_c;
  logic [IDX_W-1:0]    cur_idx_c;
  logic [DATA_LEN-1:0] cur_wdata_c;
  logic                cur_wr_c;
  logic                cur_oor_c;
  logic                ram_we_c;
  logic                ram_re_c;
  logic                ram_clr_c;
  logic                addr_unused_c;

  assign req_c    = mem_r_en | mem_w_en;
  assign in_idx_c = addr[WORD_OFFSET +: IDX_W];

  // Out-of-range detection only exists with the error feature; otherwise wrap.
`ifdef MEM_RANGE_ERR_EN
  assign in_oor_c = (addr >> (WORD_OFFSET + IDX_W)) != '0;
`else
  assign in_oor_c = 1'b0;
`endif

  // Low address bits and wrapped high bits do not affect the index.
  assign addr_unused_c = ^addr;

  // State, counter and request latches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; fire_c marks the edge that enters RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    oor_d       = oor_q;
    ready_d     = 1'b0;
    fire_c      = 1'b0;
    cur_idx_c   = idx_q;
    cur_wdata_c = wdata_q;
    cur_wr_c    = wr_q;
    cur_oor_c   = oor_q;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_clr_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          idx_d       = in_idx_c;
          wdata_d     = wdata;
          wr_d        = mem_w_en;
          oor_d       = in_oor_c;
          // Zero wait states complete on the accept edge with live inputs.
          cur_idx_c   = in_idx_c;
          cur_wdata_c = wdata;
          cur_wr_c    = mem_w_en;
          cur_oor_c   = in_oor_c;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            fire_c  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          fire_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset on the completion edge must not commit a write.
    ram_we_c  = fire_c & cur_wr_c & ~cur_oor_c & rst;
    ram_re_c  = fire_c & ~cur_wr_c & ~cur_oor_c;
    ram_clr_c = fire_c & cur_oor_c;
    ready_d   = fire_c;
  end

`ifdef MEM_RANGE_ERR_EN
  logic err_q;

  // Error flag accompanies ready for out-of-range requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire_c & cur_oor_c;
    end
  end

  assign err = err_q;
`endif

  arm_sp_ram #(
    .DATA_LEN (DATA_LEN),
    .DEPTH    (MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (ram_we_c),
    .re_i    (ram_re_c),
    .clr_i   (ram_clr_c),
    .idx_i   (cur_idx_c),
    .wdata_i (cur_wdata_c),
    .rdata_o (rdata)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_arm_data_mem_responder.sv
// Directed bench for arm_data_mem_responder: one instance with three wait
// states, one with zero. Honours MEM_RANGE_ERR_EN for the range case.
module tb_arm_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        r3, w3, r0, w0;
  logic [31:0] a3, d3, a0, d0;
  logic [31:0] rdata3, rdata0;
  logic        ready3, ready0;
  logic        err3, err0;

  int checks;
  int errors;

  arm_data_mem_responder #(
    .DATA_LEN(32), .ADDRESS_LEN(32), .MEM_DEPTH(64), .WAIT_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst(rst), .mem_r_en(r3), .mem_w_en(w3),
    .addr(a3), .wdata(d3), .rdata(rdata3), .ready(ready3)
`ifdef MEM_RANGE_ERR_EN
    , .err(err3)
`endif
  );

  arm_data_mem_responder #(
    .DATA_LEN(32), .ADDRESS_LEN(32), .MEM_DEPTH(64), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(w0),
    .addr(a0), .wdata(d0), .rdata(rdata0), .ready(ready0)
`ifdef MEM_RANGE_ERR_EN
    , .err(err0)
`endif
  );

`ifndef MEM_RANGE_ERR_EN
  assign err3 = 1'b0;
  assign err0 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction; scrambles addr/wdata right after accept.
  task automatic run_txn(input bit use0, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd,
                         output logic e, output logic low_after);
    logic rdy;
    @(negedge clk);
    if (use0) begin r0 = r; w0 = w; a0 = a; d0 = d; end
    else      begin r3 = r; w3 = w; a3 = a; d3 = d; end
    @(posedge clk);
    lat = -1;
    rd  = '0;
    e   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      rdy = use0 ? ready0 : ready3;
      if (i == 1) begin
        if (use0) begin a0 = 32'h3C; d0 = 32'hFFFF_FFFF; end
        else      begin a3 = 32'h3C; d3 = 32'hFFFF_FFFF; end
      end
      if (rdy) begin
        lat = i;
        rd  = use0 ? rdata0 : rdata3;
        e   = use0 ? err0 : err3;
        break;
      end
    end
    if (use0) begin r0 = 1'b0; w0 = 1'b0; end
    else      begin r3 = 1'b0; w3 = 1'b0; end
    @(negedge clk);
    low_after = use0 ? ~ready0 : ~ready3;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    logic        lo;
    logic        saw;

    checks = 0;
    errors = 0;
    rst = 1'b0;
    r3 = 0; w3 = 0; a3 = '0; d3 = '0;
    r0 = 0; w0 = 0; a0 = '0; d0 = '0;

    vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b1, 32'h14, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h14, 32'h0,         32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 32'h20, 32'hA5,        32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'hA5};
    vecs[6] = '{1'b0, 1'b1, 32'h08, 32'h1111_1111, 32'hA5};
    vecs[7] = '{1'b0, 1'b1, 32'h00, 32'h0BAD_F00D, 32'hA5};
    vecs[8] = '{1'b1, 1'b0, 32'h00, 32'h0,         32'h0BAD_F00D};
    vecs[9] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready3", 32'(ready3), 32'h0);
    check("rst_rdata3", rdata3, 32'h0);
    check("rst_ready0", 32'(ready0), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_err3", 32'(err3), 32'h0);
    rst = 1'b1;

    // Zero-wait instance: fill words 0 and 1
    run_txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h1, lat, rd, e, lo);
    check("w0_wr0_lat", 32'(lat), 32'd1);
    run_txn(1'b1, 1'b0, 1'b1, 32'h4, 32'h2, lat, rd, e, lo);
    check("w0_wr1_lat", 32'(lat), 32'd1);
    check("w0_wr1_pulse", 32'(lo), 32'h1);

    // Zero-wait back-to-back reads with r_en held
    @(negedge clk);
    r0 = 1'b1; a0 = 32'h0;
    @(negedge clk);
    check("b2b_rdy_a", 32'(ready0), 32'h1);
    check("b2b_rd_a", rdata0, 32'h1);
    a0 = 32'h4;
    @(negedge clk);
    check("b2b_gap", 32'(ready0), 32'h0);
    check("b2b_hold", rdata0, 32'h1);
    @(negedge clk);
    check("b2b_rdy_b", 32'(ready0), 32'h1);
    check("b2b_rd_b", rdata0, 32'h2);
    r0 = 1'b0;

    // Table-driven transactions on the three-wait instance
    for (int i = 0; i < 10; i++) begin
      run_txn(1'b0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, lat, rd, e, lo);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_pulse", i), 32'(lo), 32'h1);
      check($sformatf("vec%0d_err", i), 32'(e), 32'h0);
    end

    // Abort after one WAIT cycle
    @(negedge clk);
    w3 = 1'b1; a3 = 32'h08; d3 = 32'h55;
    @(posedge clk);
    @(negedge clk);
    check("abort_wait_ready", 32'(ready3), 32'h0);
    w3 = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready3) saw = 1'b1;
    end
    check("abort_no_ready", 32'(saw), 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, lat, rd, e, lo);
    check("abort_rd_lat", 32'(lat), 32'd4);
    check("abort_rd_data", rd, 32'h1111_1111);

    // Reset landing on the completion edge of a write
    @(negedge clk);
    w3 = 1'b1; a3 = 32'h14; d3 = 32'h9999_9999;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("rstw_pre_ready", 32'(ready3), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", 32'(ready3), 32'h0);
    check("rstw_rdata3", rdata3, 32'h0);
    check("rstw_rdata0", rdata0, 32'h0);
    w3 = 1'b0;
    rst = 1'b1;
    run_txn(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, lat, rd, e, lo);
    check("rstw_rd_lat", 32'(lat), 32'd4);
    check("rstw_rd_data", rd, 32'h1234_5678);

    // Range: addr 0x100 is word index 64
    run_txn(1'b0, 1'b0, 1'b1, 32'h100, 32'h77, lat, rd, e, lo);
    check("range_wr_lat", 32'(lat), 32'd4);
`ifdef MEM_RANGE_ERR_EN
    check("range_wr_err", 32'(e), 32'h1);
    check("range_wr_rdata", rd, 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, lat, rd, e, lo);
    check("range_rd_err", 32'(e), 32'h1);
    check("range_rd_rdata", rd, 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, rd, e, lo);
    check("range_idx0_err", 32'(e), 32'h0);
    check("range_idx0", rd, 32'h0BAD_F00D);
`else
    check("range_wr_rdata", rd, 32'h1234_5678);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, rd, e, lo);
    check("range_alias_lat", 32'(lat), 32'd4);
    check("range_alias", rd, 32'h77);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
